// File: rtl/muldiv_seq.sv
// Multicycle radix-2 multiply/divide unit: shift-add multiply, restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN ends multiply iterations once the remaining multiplier bits are zero.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             long,
  output logic             divzero,
  output logic             neg,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [2:0] OP_SMUL = 3'b101;
  localparam logic [2:0] OP_UMUL = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [2:0]         op_reg, op_next;
  logic               sign_reg, sign_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic               long_reg, long_next;
  logic               divzero_reg, divzero_next;
  logic               neg_reg, neg_next;
  logic               zero_reg, zero_next;

  logic               is_div, is_smul;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rs, diff, sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               last;

  assign is_div  = (op_reg == OP_DIV);
  assign is_smul = (op_reg == OP_SMUL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      sign_reg    <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      lo_reg      <= '0;
      hi_reg      <= '0;
      long_reg    <= 1'b0;
      divzero_reg <= 1'b0;
      neg_reg     <= 1'b0;
      zero_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      op_reg      <= op_next;
      sign_reg    <= sign_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      lo_reg      <= lo_next;
      hi_reg      <= hi_next;
      long_reg    <= long_next;
      divzero_reg <= divzero_next;
      neg_reg     <= neg_next;
      zero_reg    <= zero_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    op_next      = op_reg;
    sign_next    = sign_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    lo_next      = lo_reg;
    hi_next      = hi_reg;
    long_next    = long_reg;
    divzero_next = divzero_reg;
    neg_next     = neg_reg;
    zero_next    = zero_reg;
    abs_a        = (is_smul && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    abs_b        = (is_smul && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    rs           = acc_reg[2*WIDTH-1:WIDTH-1];
    diff         = rs - {1'b0, b_reg};
    sum          = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (b_reg[0] ? {1'b0, a_reg} : '0);
    prod         = acc_reg;
    res_lo       = '0;
    res_hi       = '0;
    last         = (cnt_reg == '0);

    case (state_reg)
      IDLE: begin
        if (start && op[2]) begin
          a_next     = a;
          b_next     = b;
          op_next    = op;
          state_next = PREP;
        end
      end
      PREP: begin
        a_next     = abs_a;
        b_next     = abs_b;
        sign_next  = is_smul & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
        // Divide keeps the dividend in the low half; it shifts out MSB first.
        acc_next   = is_div ? {{WIDTH{1'b0}}, a_reg} : '0;
        cnt_next   = CNT_INIT;
        state_next = (is_div && b_reg == '0) ? FIX : RUN;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div && abs_b == '0) state_next = FIX;
`endif
      end
      RUN: begin
        if (is_div) begin
          if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
          else              acc_next = {rs[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
          acc_next = {sum, acc_reg[WIDTH-1:1]};
          b_next   = b_reg >> 1;
`ifdef MULDIV_EARLY_OUT_EN
          if ((b_reg >> 1) == '0) last = 1'b1;
`endif
        end
        // On exit the counter holds the number of shifts still owed to the product.
        cnt_next   = last ? cnt_reg : cnt_reg - CW'(1);
        state_next = last ? FIX : RUN;
      end
      FIX: begin
`ifdef MULDIV_EARLY_OUT_EN
        prod = acc_reg >> cnt_reg;
`endif
        if (is_smul && sign_reg) prod = -prod;
        divzero_next = 1'b0;
        if (is_div) begin
          if (b_reg == '0) begin
            res_lo       = '1;
            res_hi       = a_reg;
            divzero_next = 1'b1;
          end else begin
            res_lo = acc_reg[WIDTH-1:0];
            res_hi = acc_reg[2*WIDTH-1:WIDTH];
          end
        end else begin
          res_lo = prod[WIDTH-1:0];
          res_hi = prod[2*WIDTH-1:WIDTH];
        end
        lo_next    = res_lo;
        hi_next    = res_hi;
        long_next  = (op_reg == OP_SMUL) || (op_reg == OP_UMUL);
        neg_next   = long_next ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
        zero_next  = long_next ? ({res_hi, res_lo} == '0) : (res_lo == '0);
        state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign result_lo = lo_reg;
  assign result_hi = hi_reg;
  assign long      = long_reg;
  assign divzero   = divzero_reg;
  assign neg       = neg_reg;
  assign zero      = zero_reg;

endmodule
